// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detector_pkg;

  // Widest pattern the detector supports; also sizes the fill counter.
  localparam int MAX_PAT_W = 32;

  // Fill counter width, wide enough to hold MAX_PAT_W.
  localparam int FILL_W = $clog2(MAX_PAT_W + 1);

  // Fill tracking: FILLING until PAT_W bits are held, then ARMED.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } fill_state_e;

  // Width of a saturating counter that must be able to hold full_num.
  function automatic int cnt_width(input int full_num);
    return (full_num < 1) ? 1 : $clog2(full_num + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating event counter with a sticky full flag.
// Counts i_inc pulses up to FULL_NUM. o_full rises in the same cycle that
// o_count reaches FULL_NUM and stays high until i_clr or reset.
module seq_match_counter
  import seq_detector_pkg::*;
#(
  parameter  int FULL_NUM = 8,
  localparam int CNT_W    = cnt_width(FULL_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(FULL_NUM);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             r_full;

  // Count increments with saturation; full latches on reaching FULL_NUM.
  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (i_inc && (r_count != FULL_VAL)) begin
      r_count <= r_count + ONE;
      if (r_count == FULL_VAL - ONE) begin
        r_full <= 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// Shifts in seq_in on valid_in cycles and compares the last PAT_W accepted
// bits (first-received bit = MSB) against a runtime-loadable pattern. A hit
// produces a one-cycle registered match pulse and bumps a saturating counter.
// overlap_en selects whether the bits of a hit may be reused by the next one.
// Optional macro SEQ_DETECTOR_MASK_EN adds pat_mask_in and a mask register;
// a mask bit of 0 turns the matching pattern bit into a don't-care.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter  int               PAT_W    = 4,
  parameter  logic [PAT_W-1:0] PAT_RST  = 4'b1011,
  parameter  int               FULL_NUM = 8,
  localparam int               CNT_W    = cnt_width(FULL_NUM)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             seq_in,
  input  logic             valid_in,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DETECTOR_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             clear,
  output logic             match,
  output logic             full,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  fill_state_e       r_state;
  fill_state_e       w_state_next;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_next;
  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  w_hist_next;
  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  w_pat_next;
  logic              r_match;

  logic [PAT_W-1:0]  w_shift;
  logic [PAT_W-1:0]  w_diff;
  logic              w_equal;
  logic              w_filled;
  logic              w_hit;
  logic              w_cnt_clr;

  // History as it would look after accepting the current bit.
  assign w_shift = {r_hist[PAT_W-2:0], seq_in};

`ifdef SEQ_DETECTOR_MASK_EN
  logic [PAT_W-1:0] r_mask;

  // Mask register: loads with the pattern, resets to exact-compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '1;
    end else if (pat_load) begin
      r_mask <= pat_mask_in;
    end
  end

  assign w_diff = (w_shift ^ r_pat) & r_mask;
`else
  assign w_diff = w_shift ^ r_pat;
`endif

  assign w_equal = (w_diff == '0);

  // This bit completes a full window if already armed or it is the last one.
  assign w_filled = (r_state == ARMED) || (r_fill == FILL_LAST);

  // Next-state logic: pat_load beats clear beats an accepted bit.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill;
    w_hist_next  = r_hist;
    w_pat_next   = r_pat;
    w_hit        = 1'b0;

    if (pat_load) begin
      w_pat_next   = pat_in;
      w_hist_next  = '0;
      w_fill_next  = '0;
      w_state_next = FILLING;
    end else if (clear) begin
      w_hist_next  = '0;
      w_fill_next  = '0;
      w_state_next = FILLING;
    end else if (valid_in) begin
      w_hist_next = w_shift;
      w_hit       = w_filled && w_equal;

      if (w_hit && !overlap_en) begin
        // Non-overlapping: the next match needs PAT_W fresh bits.
        w_fill_next  = '0;
        w_state_next = FILLING;
      end else if (r_state == ARMED) begin
        w_fill_next  = FILL_MAX;
        w_state_next = ARMED;
      end else if (r_fill == FILL_LAST) begin
        w_fill_next  = FILL_MAX;
        w_state_next = ARMED;
      end else begin
        w_fill_next  = r_fill + FILL_ONE;
        w_state_next = FILLING;
      end
    end
  end

  // State, history, pattern and registered match pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILLING;
      r_fill  <= '0;
      r_hist  <= '0;
      r_pat   <= PAT_RST;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
      r_hist  <= w_hist_next;
      r_pat   <= w_pat_next;
      r_match <= w_hit;
    end
  end

  // Loading a pattern keeps the count; only an explicit clear wipes it.
  assign w_cnt_clr = clear & ~pat_load;

  seq_match_counter #(
    .FULL_NUM (FULL_NUM)
  ) u_counter (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_inc   (w_hit),
    .i_clr   (w_cnt_clr),
    .o_count (match_count),
    .o_full  (full)
  );

  assign match = r_match;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param (default parameters).
// A queue-based reference model tracks accepted bits since the last restart
// and decides hits from the last PAT_W of them.
module tb_seq_detector_param;

  localparam int PAT_W    = 4;
  localparam int FULL_NUM = 8;
  localparam int CNT_W    = $clog2(FULL_NUM + 1);

  logic             clock;
  logic             reset_n;
  logic             seq_in;
  logic             valid_in;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
`ifdef SEQ_DETECTOR_MASK_EN
  logic [PAT_W-1:0] pat_mask_in;
`endif
  logic             clear;
  logic             match;
  logic             full;
  logic [CNT_W-1:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit               m_q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_count;
  bit               m_full;
  bit               m_match;

  seq_detector_param #(
    .PAT_W    (PAT_W),
    .PAT_RST  (4'b1011),
    .FULL_NUM (FULL_NUM)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .seq_in      (seq_in),
    .valid_in    (valid_in),
    .overlap_en  (overlap_en),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
`ifdef SEQ_DETECTOR_MASK_EN
    .pat_mask_in (pat_mask_in),
`endif
    .clear       (clear),
    .match       (match),
    .full        (full),
    .match_count (match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pat   = 4'b1011;
    m_count = 0;
    m_full  = 1'b0;
    m_match = 1'b0;
  endtask

  // Model of one clock edge with the given inputs.
  task automatic model_step(input logic v, input logic b, input logic ov,
                            input logic ld, input logic [PAT_W-1:0] p, input logic cl);
    logic [PAT_W-1:0] window;
    m_match = 1'b0;
    if (ld) begin
      m_pat = p;
      m_q.delete();
    end else if (cl) begin
      m_q.delete();
      m_count = 0;
      m_full  = 1'b0;
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      if (m_q.size() == PAT_W) begin
        window = '0;
        foreach (m_q[i]) window = {window[PAT_W-2:0], m_q[i]};
        if (window == m_pat) begin
          m_match = 1'b1;
          if (m_count < FULL_NUM) m_count++;
          if (m_count == FULL_NUM) m_full = 1'b1;
          if (!ov) m_q.delete();
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, sample outputs 1 time unit after the edge.
  task automatic cyc(input logic v, input logic b, input logic ov,
                     input logic ld, input logic [PAT_W-1:0] p, input logic cl);
    valid_in   = v;
    seq_in     = b;
    overlap_en = ov;
    pat_load   = ld;
    pat_in     = p;
    clear      = cl;
    model_step(v, b, ov, ld, p, cl);
    @(posedge clock);
    #1;
    check("match", 32'(match), 32'(m_match));
    check("match_count", 32'(match_count), 32'(m_count));
    check("full", 32'(full), 32'(m_full));
  endtask

  task automatic bit_in(input logic b, input logic ov);
    cyc(1'b1, b, ov, 1'b0, '0, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [6:0] stream7;
    logic [3:0] p1011;
    logic [3:0] p0110;
    stream7 = 7'b1011011;
    p1011   = 4'b1011;
    p0110   = 4'b0110;

    reset_n    = 1'b0;
    seq_in     = 1'b0;
    valid_in   = 1'b0;
    overlap_en = 1'b1;
    pat_load   = 1'b0;
    pat_in     = '0;
    clear      = 1'b0;
`ifdef SEQ_DETECTOR_MASK_EN
    pat_mask_in = '1;
`endif
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    reset_n = 1'b1;

    // Overlap on, 1011 -> one pulse one cycle after the 4th bit.
    for (int i = 3; i >= 0; i--) bit_in(p1011[i], 1'b1);
    check("first_hit_count", 32'(match_count), 32'd1);

    // Overlap on, 1011011 -> two pulses.
    do_clear();
    for (int i = 6; i >= 0; i--) bit_in(stream7[i], 1'b1);
    check("overlap_two_hits", 32'(match_count), 32'd2);

    // Overlap off, same stream -> one pulse.
    do_clear();
    for (int i = 6; i >= 0; i--) bit_in(stream7[i], 1'b0);
    check("nonoverlap_one_hit", 32'(match_count), 32'd1);

    // 1011 with idle gaps; seq_in wiggles while valid_in is low.
    do_clear();
    for (int i = 3; i >= 0; i--) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) cyc(1'b0, 1'($urandom), 1'b1, 1'b0, '0, 1'b0);
      bit_in(p1011[i], 1'b1);
    end
    check("gapped_hit", 32'(match_count), 32'd1);

    // Nine non-overlapping hits: saturate at 8, full sticky, pulses continue.
    do_clear();
    for (int k = 0; k < 9; k++) begin
      for (int i = 3; i >= 0; i--) bit_in(p1011[i], 1'b0);
      if (k == 7) check("full_at_8", 32'(full), 32'd1);
    end
    check("sat_count", 32'(match_count), 32'(FULL_NUM));
    check("sat_full", 32'(full), 32'd1);
    do_clear();
    check("clear_count", 32'(match_count), 32'd0);
    check("clear_full", 32'(full), 32'd0);

    // Mid-stream load of 0110 with a concurrent valid bit that must be dropped.
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, p0110, 1'b0);
    for (int i = 3; i >= 0; i--) bit_in(p0110[i], 1'b1);
    check("load_hit", 32'(match_count), 32'd1);
    for (int i = 3; i >= 0; i--) bit_in(p1011[i], 1'b1);
    check("old_pat_dead", 32'(match_count), 32'd1);

    // Async reset mid-pattern (pattern returns to 1011).
    for (int i = 3; i >= 1; i--) bit_in(p1011[i], 1'b1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_match", 32'(match), 32'd0);
    check("async_count", 32'(match_count), 32'd0);
    check("async_full", 32'(full), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bit_in(1'b1, 1'b1);
    check("post_rst_no_hit", 32'(match), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic v, b, ov, ld, cl;
      logic [PAT_W-1:0] p;
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      ov = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 79) == 0);
      cl = ($urandom_range(0, 63) == 0);
      p  = PAT_W'($urandom);
      cyc(v, b, ov, ld, p, cl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
